// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   Byte-addressed, word-organised data RAM for the MEM stage. Supports
//   byte/half/word stores with little-endian byte lanes, sign/zero-extended
//   loads with one cycle of latency, alignment/range rejection, and a
//   post-reset sequencer that clears (or preloads) every word before
//   requests are accepted.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; restarts the clear sequence
//   address       byte address; word index = address >> 2
//   datain        store data, right-aligned
//   dataRead      load request
//   dataWrite     store request
//   size          00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned 1 = zero-extend byte/half loads, 0 = sign-extend
//   dataout       registered load data, holds between loads
//   data_valid    one-cycle pulse when dataout was updated by a load
//   access_err    one-cycle pulse when a request was rejected
//   busy          clear sequence in progress; requests are ignored
//
// Handshake: there is no back-pressure. While busy is low, a request is a
// single-cycle assertion of dataRead or dataWrite sampled at the clk edge;
// exactly one of data_valid (accepted load), access_err (rejected request)
// or nothing (accepted store) pulses in the following cycle.
module data_memory_bytelane #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 32,
    parameter bit PRELOAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       datain,
    input  logic              dataRead,
    input  logic              dataWrite,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [31:0]       dataout,
    output logic              data_valid,
    output logic              access_err,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PTR_W-1:0]  clr_ptr;
    logic              clear_last;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [PTR_W-1:0]  idx;
    logic              in_range;
    logic              req;
    logic              reject;
    logic              do_load;
    logic              do_store;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    // Value written to a word during the clear sequence.
    function automatic logic [31:0] clear_value(input logic [PTR_W-1:0] p);
        logic [31:0] v;
        v = 32'd0;
        if (PRELOAD) begin
            case (int'(p))
                0:       v = 32'd5;
                1:       v = 32'd3;
                2:       v = 32'd0;
                3:       v = 32'd1;
                4:       v = 32'd2;
                5:       v = 32'd4;
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR && !clear_last) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        clear_last = (clr_ptr == PTR_W'(DEPTH - 1));
        busy       = (state == CLEAR);
        case (state)
            CLEAR:   if (clear_last) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    // ---------------- request decode ----------------
    assign word_idx = address >> 2;
    assign idx      = word_idx[PTR_W-1:0];
    assign in_range = (word_idx < ADDR_W'(DEPTH));

    always_comb begin
        req    = (state == READY) && (dataRead || dataWrite);
        reject = 1'b0;
        if (req) begin
            if (dataRead && dataWrite)                          reject = 1'b1;
            if (size == 2'b11)                                  reject = 1'b1;
            if (size == 2'b01 && address[0])                    reject = 1'b1;
            if (size == 2'b10 && address[1:0] != 2'b00)         reject = 1'b1;
            if (!in_range)                                      reject = 1'b1;
        end
        do_load  = req && !reject && dataRead;
        do_store = req && !reject && dataWrite;
    end

    // ---------------- write port (clear sequencer or store) ----------------
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_data = 32'd0;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_ptr;
            wr_be   = 4'b1111;
            wr_data = clear_value(clr_ptr);
        end else if (do_store) begin
            wr_en = 1'b1;
            case (size)
                2'b00: begin
                    wr_be   = 4'b0001 << address[1:0];
                    wr_data = {4{datain[7:0]}};
                end
                2'b01: begin
                    wr_be   = address[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{datain[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = datain;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- load path ----------------
    // The array is read before the edge, so a store at edge N is visible to
    // a load at edge N+1 without any bypass.
    always_comb begin
        rd_word = mem[idx];
        case (address[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_data = load_unsigned ? {24'd0, rd_byte}
                                               : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = load_unsigned ? {16'd0, rd_half}
                                               : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataout    <= 32'd0;
            data_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            data_valid <= do_load;
            access_err <= reject;
            if (do_load) begin
                dataout <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;

  localparam int DEPTH = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] datain = '0;
  logic        dataRead = 1'b0;
  logic        dataWrite = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        load_unsigned = 1'b0;
  logic [31:0] dataout;
  logic        data_valid;
  logic        access_err;
  logic        busy;

  always #5 clk = ~clk;

  data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_W(32), .PRELOAD(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .datain(datain),
    .dataRead(dataRead), .dataWrite(dataWrite), .size(size),
    .load_unsigned(load_unsigned), .dataout(dataout),
    .data_valid(data_valid), .access_err(access_err), .busy(busy)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_dout;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model for random phase ----------------
  logic [31:0] model_mem[DEPTH];

  task automatic model_init();
    logic [31:0] pre[6];
    pre = '{32'd5, 32'd3, 32'd0, 32'd1, 32'd2, 32'd4};
    for (int i = 0; i < DEPTH; i++) model_mem[i] = (i < 6) ? pre[i] : 32'd0;
  endtask

  task automatic model_store(input int wi, input int off, input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   model_mem[wi][8*off +: 8]  = d[7:0];
      2'b01:   model_mem[wi][8*off +: 16] = d[15:0];
      default: model_mem[wi] = d;
    endcase
  endtask

  function automatic logic [31:0] model_load(input int wi, input int off, input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model_mem[wi];
    b = w[8*off +: 8];
    h = w[8*off +: 16];
    case (sz)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    dataRead  = 1'b0;
    dataWrite = 1'b0;
  endtask

  // Drive one request for one edge, then check the response pulses.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [1:0] sz, input logic uns, input logic [31:0] din,
                     input logic exp_err, input logic [31:0] exp_data);
    logic exp_valid;
    logic [31:0] e;
    dataRead      = rd;
    dataWrite     = wr;
    address       = addr;
    size          = sz;
    load_unsigned = uns;
    datain        = din;
    exp_valid     = rd && !wr && !exp_err;
    if (exp_valid) begin
      exp_q.push_back(exp_data);
      exp_dout = exp_data;
    end
    @(posedge clk); #1;
    chk($sformatf("access_err@%h", addr), {31'd0, access_err}, {31'd0, exp_err});
    chk($sformatf("data_valid@%h", addr), {31'd0, data_valid}, {31'd0, exp_valid});
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("load@%h", addr), dataout, e);
      end
    end else begin
      chk($sformatf("dataout_hold@%h", addr), dataout, exp_dout);
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_dataout", dataout, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_err", {31'd0, access_err}, 32'd0);
    exp_q.delete();
    exp_dout = 32'd0;
    reset = 1'b0;
  endtask

  // Count busy cycles from reset release while hammering junk requests.
  task automatic wait_clear();
    int cnt;
    bit quiet;
    cnt   = 0;
    quiet = 1'b1;
    address = 32'h0;
    size    = 2'b10;
    datain  = 32'hFFFF_FFFF;
    while (busy && cnt < 1000) begin
      dataWrite = cnt[0];
      dataRead  = ~cnt[0];
      if (data_valid || access_err) quiet = 1'b0;
      cnt++;
      @(posedge clk); #1;
    end
    if (data_valid || access_err) quiet = 1'b0;
    idle();
    chk("busy_cycles", cnt, DEPTH);
    chk("busy_quiet", {31'd0, quiet}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] din;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [1:0] sz, input logic uns, input logic [31:0] din,
                              input logic err, input logic [31:0] exp);
    vec_t v;
    v = '{rd, wr, addr, sz, uns, din, err, exp};
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    exp_dout = 32'd0;

    // preload readback
    add(1, 0, 32'h00, 2'b10, 0, 0, 0, 32'h0000_0005);
    add(1, 0, 32'h04, 2'b10, 0, 0, 0, 32'h0000_0003);
    add(1, 0, 32'h08, 2'b10, 0, 0, 0, 32'h0000_0000);
    add(1, 0, 32'h14, 2'b10, 0, 0, 0, 32'h0000_0004);
    add(1, 0, 32'h18, 2'b10, 0, 0, 0, 32'h0000_0000);
    // word store then narrow loads
    add(0, 1, 32'h40, 2'b10, 0, 32'hDEAD_BEEF, 0, 0);
    add(1, 0, 32'h40, 2'b10, 0, 0, 0, 32'hDEAD_BEEF);
    add(1, 0, 32'h42, 2'b01, 1, 0, 0, 32'h0000_DEAD);
    add(1, 0, 32'h42, 2'b01, 0, 0, 0, 32'hFFFF_DEAD);
    add(1, 0, 32'h41, 2'b00, 1, 0, 0, 32'h0000_00BE);
    add(1, 0, 32'h41, 2'b00, 0, 0, 0, 32'hFFFF_FFBE);
    add(1, 0, 32'h40, 2'b10, 1, 0, 0, 32'hDEAD_BEEF);
    // lane merge into a cleared word
    add(0, 1, 32'h10, 2'b10, 0, 32'h0, 0, 0);
    add(0, 1, 32'h11, 2'b00, 0, 32'h1234_56AB, 0, 0);
    add(1, 0, 32'h10, 2'b10, 0, 0, 0, 32'h0000_AB00);
    add(0, 1, 32'h12, 2'b01, 0, 32'h0000_7788, 0, 0);
    add(1, 0, 32'h10, 2'b10, 0, 0, 0, 32'h7788_AB00);
    // rejects
    add(0, 1, 32'h20, 2'b10, 0, 32'hCAFE_F00D, 0, 0);
    add(1, 0, 32'h20, 2'b10, 0, 0, 0, 32'hCAFE_F00D);
    add(1, 0, 32'h22, 2'b10, 0, 0, 1, 0);
    add(1, 0, 32'h23, 2'b01, 0, 0, 1, 0);
    add(1, 0, 32'h20, 2'b11, 0, 0, 1, 0);
    add(1, 1, 32'h20, 2'b10, 0, 32'hFFFF_FFFF, 1, 0);
    add(0, 1, 32'h21, 2'b01, 0, 32'hFFFF_FFFF, 1, 0);
    add(0, 1, 32'h100, 2'b10, 0, 32'hFFFF_FFFF, 1, 0);
    add(1, 0, 32'h20, 2'b10, 0, 0, 0, 32'hCAFE_F00D);
    add(1, 0, 32'h00, 2'b10, 0, 0, 0, 32'h0000_0005);
    // top word boundary
    add(0, 1, 32'hFC, 2'b10, 0, 32'hA5A5_5A5A, 0, 0);
    add(1, 0, 32'hFE, 2'b01, 1, 0, 0, 32'h0000_A5A5);
    add(1, 0, 32'hFC, 2'b00, 0, 0, 0, 32'h0000_005A);
    // back-to-back store/load
    add(0, 1, 32'h30, 2'b10, 0, 32'h1111_1111, 0, 0);
    add(1, 0, 32'h30, 2'b10, 0, 0, 0, 32'h1111_1111);

    // Reset and clear with ignored requests
    do_reset();
    wait_clear();

    foreach (vecs[i])
      req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].uns,
          vecs[i].din, vecs[i].err, vecs[i].exp);
    idle();
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, data_valid}, 32'd0);
    chk("idle_err", {31'd0, access_err}, 32'd0);
    chk("idle_hold", dataout, exp_dout);

    // Reset in the middle of the clear sequence
    req(0, 1, 32'h80, 2'b10, 0, 32'h0000_0055, 0, 0);
    req(1, 0, 32'h80, 2'b10, 0, 0, 0, 32'h0000_0055);
    idle();
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("midclear_busy", {31'd0, busy}, 32'd1);
    do_reset();
    wait_clear();
    req(1, 0, 32'h80, 2'b10, 0, 0, 0, 32'h0000_0000);
    req(1, 0, 32'h00, 2'b10, 0, 0, 0, 32'h0000_0005);

    // Random legal traffic against the model
    model_init();
    for (int i = 0; i < 60; i++) begin
      int          wi;
      int          off;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] d;
      wi  = $urandom_range(0, DEPTH - 1);
      sz  = 2'($urandom_range(0, 2));
      off = (sz == 2'b00) ? $urandom_range(0, 3) : (sz == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
      uns = 1'($urandom_range(0, 1));
      d   = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        model_store(wi, off, sz, d);
        req(0, 1, 32'(wi * 4 + off), sz, uns, d, 0, 0);
      end else begin
        req(1, 0, 32'(wi * 4 + off), sz, uns, d, 0, model_load(wi, off, sz, uns));
      end
    end
    idle();
    @(posedge clk); #1;

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
